// File: rtl/mult_div_sequencer.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit
// with its own sequencer and HI/LO result registers.
//
// Ports:
//   clock, reset   rising-edge clock, async active-high reset
//   start, op      launch request; op 0 = signed mul, 1 = signed div
//   a, b           operands (rs, rt), latched when a launch is accepted
//   busy           high while an operation is in flight
//   done, div0     one-cycle completion / divide-by-zero pulses
//   hi, lo         HI and LO result registers
module mult_div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int PW = 2 * WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    MULT_RUN,
    DIV_RUN,
    DIV_FIX,
    DONE
  } state_t;

  state_t state;

  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             sign_a;
  logic             sign_b;

  // Booth step: the accumulator is widened by one bit so that
  // subtracting the most negative multiplicand cannot overflow;
  // the arithmetic shift folds the extra bit back in.
  logic [WIDTH:0] booth_hi;
  logic [WIDTH:0] booth_sum;
  logic [WIDTH:0] mcand_x;
  logic [PW-1:0]  prod_nxt;

  always_comb begin
    booth_hi = {prod[PW-1], prod[PW-1:WIDTH+1]};
    mcand_x  = {mcand[WIDTH-1], mcand};
    unique case (prod[1:0])
      2'b01:   booth_sum = booth_hi + mcand_x;
      2'b10:   booth_sum = booth_hi - mcand_x;
      default: booth_sum = booth_hi;
    endcase
    prod_nxt = {booth_sum, prod[WIDTH:1]};
  end

  // Restoring division step on magnitudes; quo shifts out
  // dividend bits from the top while quotient bits enter below.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  always_comb begin
    rem_sh  = {rem, quo[WIDTH-1]};
    trial   = rem_sh - {1'b0, dvs};
    q_bit   = ~trial[WIDTH];
    rem_nxt = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], q_bit};
  end

  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    q_fix = (sign_a ^ sign_b) ? -quo : quo;
    r_fix = sign_a ? -rem : rem;
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt    <= '0;
            mcand  <= a;
            prod   <= {{(WIDTH+1){1'b0}}, b, 1'b0};
            rem    <= '0;
            quo    <= a_mag;
            dvs    <= b_mag;
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
            if (!op) begin
              state <= MULT_RUN;
              busy  <= 1'b1;
            end else if (b == '0) begin
              state <= DONE;
              done  <= 1'b1;
              div0  <= 1'b1;
            end else begin
              state <= DIV_RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        MULT_RUN: begin
          prod <= prod_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            hi    <= prod_nxt[PW-1:WIDTH+1];
            lo    <= prod_nxt[WIDTH:1];
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DIV_RUN: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DIV_FIX;
        end
        DIV_FIX: begin
          hi    <= r_fix;
          lo    <= q_fix;
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
- Multicycle signed multiply/divide unit with its own sequencing FSM and HI/LO result registers.
- Serves the MULT (funct 0x18) and DIV (funct 0x1a) paths of the CPU control unit, which raises start for one cycle and waits for done.
- MFHI/MFLO read the hi/lo outputs directly.
- Raises div0 toward the exception logic on divide-by-zero.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  launch request; sampled only when accepting.
- op  input  1  0 = signed multiply, 1 = signed divide.
- a  input  WIDTH  multiplicand / dividend (rs), sampled with start.
- b  input  WIDTH  multiplier / divisor (rt), sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- div0  output  1  one-cycle divide-by-zero pulse, coincident with done.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, div0=0, hi=0, lo=0.
  - Counter and internal operand registers cleared; an in-flight operation is discarded.
- States: IDLE, MULT_RUN, DIV_RUN, DIV_FIX, DONE. All outputs registered.
- Accepting states: IDLE and DONE. start sampled high there launches an operation; in all other states start is ignored.
- On accept:
  - Latch a, b, op; counter=0.
  - op=0 -> MULT_RUN.
  - op=1, b!=0 -> DIV_RUN.
  - op=1, b==0 -> DONE with div0=1; hi/lo unchanged.
- MULT_RUN:
  - Radix-2 Booth over 2*WIDTH+1-bit product register, one bit per cycle, WIDTH cycles.
  - After the last iteration: hi=product[2W-1:W], lo=product[W-1:0], written on the edge entering DONE.
  - Result is the full signed 2W-bit product; no overflow indication.
- DIV_RUN:
  - Restoring division on magnitudes |a|, |b| (unsigned WIDTH bits, so -2^(W-1) is representable), one quotient bit per cycle, WIDTH cycles.
  - Then DIV_FIX.
- DIV_FIX (1 cycle):
  - Negate quotient if sign(a)!=sign(b); remainder takes the sign of a.
  - lo=quotient, hi=remainder, written on the edge entering DONE.
  - -2^(W-1) / -1 gives lo=0x80000000, hi=0; no exception.
- DONE (1 cycle):
  - done=1; hi/lo already hold the new result in this cycle.
  - Goes to IDLE unless start is high, in which case it launches (back-to-back).
- busy:
  - 1 in MULT_RUN, DIV_RUN, DIV_FIX; 0 in IDLE and DONE.
  - Rises in the cycle after an accepted start.
- Latency, with the start edge as cycle 0:
  - Multiply: done in cycle WIDTH+1 (33).
  - Divide: done in cycle WIDTH+2 (34).
  - Divide by zero: done and div0 in cycle 1.
- hi/lo change only on the edge entering DONE after a non-div0 operation. They hold otherwise, including across div0 and ignored starts.
- Operands are latched at accept; changes on a/b during busy have no effect.

Test Plan:
- Multiply: reset; start op=0 a=7 b=0xFFFFFFFD -> busy=1 cycles 1–32; done=1 cycle 33 only; hi=0xFFFFFFFF, lo=0xFFFFFFEB; div0=0.
- Divide:
  - op=1 a=100 b=7 -> done cycle 34; lo=14, hi=2.
  - a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x12, lo=0x34 via a prior op; start op=1 b=0 -> done=1 and div0=1 in cycle 1 only, busy never high, hi/lo remain 0x12/0x34.
- Ignored start and operand hold: pulse start with new operands at cycles 5 and 20 of a multiply, and change a/b mid-run -> result matches the original operands; done pulses once.
- Back-to-back and extreme operands: start held during DONE of a multiply -> second op accepted, busy=1 next cycle. Multiply 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- Reset mid-operation: assert reset asynchronously (between clock edges) at cycle 10 of a divide -> busy, done, hi, lo immediately 0. After release, a new multiply 3×4 completes with lo=12, hi=0 at cycle 33.
